// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the two data-memory requesters and the arbiter.
interface dmem_arbiter_if;
  logic        p_req;
  logic        p_we;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;
  logic        p_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_busy;

  modport master (
    output p_req, p_we, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata,
    input  p_rdata, p_stall, d_rdata, d_ack, mem_busy
  );

  modport slave (
    input  p_req, p_we, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata,
    output p_rdata, p_stall, d_rdata, d_ack, mem_busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data RAM shared by the pipeline MEM stage and a debug/loader port.
// Fixed LAT-cycle accesses, pipeline priority with a starvation guard for debug.
module dmem_arbiter #(
  parameter int DEPTH_LOG2 = 5,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          clrn,
  dmem_arbiter_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_P, BUSY_D} state_t;

  state_t        r_state;
  logic          r_owner;   // 0 = pipeline, 1 = debug
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_starve;

  // Power-on image: word i = i for i = 1..8; reset never touches it.
  logic [31:0] r_ram [DEPTH] = '{1: 32'd1, 2: 32'd2, 3: 32'd3, 4: 32'd4,
                                 5: 32'd5, 6: 32'd6, 7: 32'd7, 8: 32'd8,
                                 default: 32'd0};

  logic [DEPTH_LOG2-1:0] w_p_idx, w_d_idx;
  logic w_idle, w_grant_p, w_grant_d, w_own_req, w_busy_done, w_done_p, w_done_d;
  logic w_unused;

  assign w_p_idx = bus.p_addr[DEPTH_LOG2+1:2];
  assign w_d_idx = bus.d_addr[DEPTH_LOG2+1:2];
  assign w_unused = ^{bus.p_addr[31:DEPTH_LOG2+2], bus.p_addr[1:0],
                      bus.d_addr[31:DEPTH_LOG2+2], bus.d_addr[1:0]};

  // Idle arbitration: pipeline first unless debug has waited STARVE_MAX grants.
  assign w_idle    = (r_state == IDLE);
  assign w_grant_d = w_idle && !clrn && bus.d_req && (!bus.p_req || r_starve == STARVE_TOP);
  assign w_grant_p = w_idle && !clrn && bus.p_req && !w_grant_d;

  // A busy access finishes on its last count only if the owner still requests.
  assign w_own_req   = r_owner ? bus.d_req : bus.p_req;
  assign w_busy_done = !w_idle && !clrn && w_own_req && (r_cnt == CNT_LAST);
  assign w_done_p    = (LAT == 1) ? w_grant_p : (w_busy_done && !r_owner);
  assign w_done_d    = (LAT == 1) ? w_grant_d : (w_busy_done && r_owner);

  // Read data is the pre-write word, visible only in the owner's completion cycle.
  assign bus.p_stall  = bus.p_req && !w_done_p;
  assign bus.p_rdata  = w_done_p ? r_ram[w_p_idx] : '0;
  assign bus.d_ack    = w_done_d;
  assign bus.d_rdata  = w_done_d ? r_ram[w_d_idx] : '0;
  assign bus.mem_busy = !w_idle;

  // Access FSM, latency counter and debug starvation counter.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_cnt    <= '0;
      r_starve <= '0;
    end else begin
      if (!bus.d_req || w_done_d)
        r_starve <= '0;
      else if (w_done_p && r_starve != STARVE_TOP)
        r_starve <= r_starve + 1'b1;

      case (r_state)
        IDLE: begin
          if (w_grant_p || w_grant_d) begin
            r_owner <= w_grant_d;
            if (LAT > 1) begin
              r_state <= w_grant_d ? BUSY_D : BUSY_P;
              r_cnt   <= CW'(1);
            end
          end
        end
        default: begin
          if (!w_own_req || r_cnt == CNT_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // RAM write at the edge closing a completing store; dropped while in reset.
  always_ff @(posedge clk) begin
    if (w_done_p && bus.p_we)
      r_ram[w_p_idx] <= bus.p_wdata;
    else if (w_done_d && bus.d_we)
      r_ram[w_d_idx] <= bus.d_wdata;
  end
endmodule
